// File: rtl/lc3_ctrl_fsm.sv
// lc3_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/WB controller for the 16-bit, 8-register core.
// Drives register file selects and write port, and owns the PC and NZP condition codes.
module lc3_ctrl_fsm #(
    parameter logic [15:0] PC_RESET = 16'h3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr_data,
    output logic        instr_ready,
    output logic [15:0] pc,
    input  logic [15:0] SR1_value,
    input  logic [15:0] SR2_value,
    output logic [2:0]  SR1,
    output logic [2:0]  SR2,
    output logic [2:0]  DR,
    output logic        RegWE,
    output logic [15:0] write_value,
    output logic [2:0]  nzp,
    output logic        halted
);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StWb, StHalt} state_t;

    localparam logic [3:0] OpBr   = 4'b0000;
    localparam logic [3:0] OpAdd  = 4'b0001;
    localparam logic [3:0] OpAnd  = 4'b0101;
    localparam logic [3:0] OpNot  = 4'b1001;
    localparam logic [3:0] OpLea  = 4'b1110;
    localparam logic [3:0] OpTrap = 4'b1111;

    state_t      state_q;
    logic [15:0] ir_q, pc_q, result_q;
    logic [2:0]  nzp_q, sr1_q, sr2_q, dr_q;
    logic        ready_q, regwe_q, halted_q, br_taken_q;

    logic [3:0]  opcode;
    logic [15:0] imm5, off9, operand2, alu_result;
    logic        is_write, sets_cc, br_taken;
    logic [2:0]  nzp_next;

    // Decode of the held instruction and the EXEC-stage datapath.
    always_comb begin
        opcode     = ir_q[15:12];
        imm5       = {{11{ir_q[4]}}, ir_q[4:0]};
        off9       = {{7{ir_q[8]}}, ir_q[8:0]};
        operand2   = ir_q[5] ? imm5 : SR2_value;
        alu_result = 16'h0000;
        is_write   = 1'b0;
        sets_cc    = 1'b0;
        case (opcode)
            OpAdd: begin alu_result = SR1_value + operand2; is_write = 1'b1; sets_cc = 1'b1; end
            OpAnd: begin alu_result = SR1_value & operand2; is_write = 1'b1; sets_cc = 1'b1; end
            OpNot: begin alu_result = ~SR1_value;           is_write = 1'b1; sets_cc = 1'b1; end
            OpLea: begin alu_result = pc_q + off9;          is_write = 1'b1; end
            default: ;
        endcase
        br_taken = (opcode == OpBr) && (|(ir_q[11:9] & nzp_q));
        if (result_q[15])              nzp_next = 3'b100;
        else if (result_q == 16'h0000) nzp_next = 3'b010;
        else                           nzp_next = 3'b001;
    end

    // Controller state machine; every output is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFetch;
            ir_q       <= 16'h0000;
            pc_q       <= PC_RESET;
            result_q   <= 16'h0000;
            nzp_q      <= 3'b010;
            sr1_q      <= 3'd0;
            sr2_q      <= 3'd0;
            dr_q       <= 3'd0;
            ready_q    <= 1'b0;
            regwe_q    <= 1'b0;
            halted_q   <= 1'b0;
            br_taken_q <= 1'b0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (instr_valid && ready_q) begin
                        ir_q    <= instr_data;
                        pc_q    <= pc_q + 16'd1;
                        // Selects load with the word so read data settles before EXEC.
                        sr1_q   <= instr_data[8:6];
                        sr2_q   <= instr_data[2:0];
                        dr_q    <= instr_data[11:9];
                        ready_q <= 1'b0;
                        state_q <= StDecode;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                StDecode: state_q <= StExec;
                StExec: begin
                    br_taken_q <= br_taken;
                    regwe_q    <= is_write;
                    if (is_write) result_q <= alu_result;
                    if (opcode == OpTrap) begin
                        halted_q <= 1'b1;
                        state_q  <= StHalt;
                    end else begin
                        state_q  <= StWb;
                    end
                end
                StWb: begin
                    regwe_q    <= 1'b0;
                    br_taken_q <= 1'b0;
                    if (sets_cc) nzp_q <= nzp_next;
                    if (br_taken_q) pc_q <= pc_q + off9;
                    ready_q    <= 1'b1;
                    state_q    <= StFetch;
                end
                StHalt: state_q <= StHalt;
                default: state_q <= StFetch;
            endcase
        end
    end

    // Handshake and write enable are masked by reset in the same cycle.
    assign instr_ready = ready_q & ~rst;
    assign RegWE       = regwe_q & ~rst;
    assign pc          = pc_q;
    assign SR1         = sr1_q;
    assign SR2         = sr2_q;
    assign DR          = dr_q;
    assign write_value = result_q;
    assign nzp         = nzp_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// tb_lc3_ctrl_fsm: directed program run against an ISA model with a write-back scoreboard.
module tb_lc3_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic        instr_ready;
    logic [15:0] pc;
    logic [15:0] SR1_value, SR2_value;
    logic [2:0]  SR1, SR2, DR;
    logic        RegWE;
    logic [15:0] write_value;
    logic [2:0]  nzp;
    logic        halted;

    typedef struct packed {
        logic [2:0]  dr;
        logic [15:0] val;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_acc = 0;
    logic [15:0] regs[8];
    logic        clr_regs;
    logic [15:0] m_reg[8];
    logic [15:0] m_pc;
    logic [2:0]  m_nzp;
    logic        m_halted;

    lc3_ctrl_fsm #(.PC_RESET(16'h3000)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_ready (instr_ready),
        .pc          (pc),
        .SR1_value   (SR1_value),
        .SR2_value   (SR2_value),
        .SR1         (SR1),
        .SR2         (SR2),
        .DR          (DR),
        .RegWE       (RegWE),
        .write_value (write_value),
        .nzp         (nzp),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Register file: combinational reads, write on the rising edge.
    always @(posedge clk) begin
        if (clr_regs) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
        end else if (RegWE) begin
            regs[DR] <= write_value;
        end
    end
    assign SR1_value = regs[SR1];
    assign SR2_value = regs[SR2];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write-back monitor: every RegWE cycle must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        #1;
        if (RegWE === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {15'b0, RegWE}, 16'h0000);
            end else begin
                e = exp_q.pop_front();
                chk("wb_dr", {13'b0, DR}, {13'b0, e.dr});
                chk("wb_value", write_value, e.val);
            end
        end
    end

    // Reference ISA model, applied at the moment an instruction is accepted.
    task automatic model_exec(input logic [15:0] w);
        logic [15:0] imm, off, b, r;
        logic        wr, cc;
        wr    = 1'b0;
        cc    = 1'b0;
        r     = 16'h0000;
        m_pc  = m_pc + 16'd1;
        imm   = {{11{w[4]}}, w[4:0]};
        off   = {{7{w[8]}}, w[8:0]};
        b     = w[5] ? imm : m_reg[w[2:0]];
        case (w[15:12])
            4'h1: begin r = m_reg[w[8:6]] + b; wr = 1'b1; cc = 1'b1; end
            4'h5: begin r = m_reg[w[8:6]] & b; wr = 1'b1; cc = 1'b1; end
            4'h9: begin r = ~m_reg[w[8:6]];    wr = 1'b1; cc = 1'b1; end
            4'hE: begin r = m_pc + off;        wr = 1'b1; end
            4'h0: if (|(w[11:9] & m_nzp)) m_pc = m_pc + off;
            4'hF: m_halted = 1'b1;
            default: ;
        endcase
        if (wr) begin
            m_reg[w[11:9]] = r;
            exp_q.push_back({w[11:9], r});
        end
        if (cc) m_nzp = r[15] ? 3'b100 : ((r == 16'h0000) ? 3'b010 : 3'b001);
    endtask

    task automatic do_reset(input logic clear);
        rst         = 1'b1;
        instr_valid = 1'b0;
        clr_regs    = clear;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 16'h3000);
        chk("rst_nzp", {13'b0, nzp}, 16'h0002);
        chk("rst_halted", {15'b0, halted}, 16'h0000);
        chk("rst_sel", {4'b0, SR1, SR2, DR}, 16'h0000);
        chk("rst_write_value", write_value, 16'h0000);
        chk("rst_ready", {15'b0, instr_ready}, 16'h0000);
        chk("rst_regwe", {15'b0, RegWE}, 16'h0000);
        rst      = 1'b0;
        clr_regs = 1'b0;
        #1;
        chk("ready_cycle_after_reset", {15'b0, instr_ready}, 16'h0000);
        if (clear) for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
        m_pc     = 16'h3000;
        m_nzp    = 3'b010;
        m_halted = 1'b0;
    endtask

    // Present one word, wait for accept, then run through WB and compare state.
    task automatic run_instr(input logic [15:0] w, input logic check_gap);
        int n;
        int acc;
        instr_valid = 1'b1;
        instr_data  = w;
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", {15'b0, instr_ready}, 16'h0001);
        acc = cyc + 1;
        if (check_gap) chk("accept_gap", 16'(acc - last_acc), 16'd4);
        last_acc = acc;
        model_exec(w);
        repeat (4) @(negedge clk);
        chk("pc", pc, m_pc);
        chk("nzp", {13'b0, nzp}, {13'b0, m_nzp});
        chk("halted", {15'b0, halted}, {15'b0, m_halted});
        chk("ready_after", {15'b0, instr_ready}, {15'b0, ~m_halted});
    endtask

    initial begin
        int n;
        instr_data = 16'h0000;
        do_reset(1'b1);

        // ADD then NOT, back to back
        run_instr(16'h1261, 1'b0);
        chk("add_nzp", {13'b0, nzp}, 16'h0001);
        run_instr(16'h947F, 1'b1);
        chk("not_pc", pc, 16'h3002);
        chk("not_nzp", {13'b0, nzp}, 16'h0004);
        // BRn #-3 taken back to 0x3000
        run_instr(16'h09FD, 1'b1);
        chk("br_taken_pc", pc, 16'h3000);
        run_instr(16'h1261, 1'b1);
        run_instr(16'h947F, 1'b1);
        // BRz #-3 not taken with nzp=100
        run_instr(16'h05FD, 1'b1);
        chk("br_not_taken_pc", pc, 16'h3003);
        // Mask 000 never taken, mask 111 always taken
        run_instr(16'h01FD, 1'b1);
        chk("br_mask000_pc", pc, 16'h3004);
        run_instr(16'h0FFD, 1'b1);
        chk("br_mask111_pc", pc, 16'h3002);
        run_instr(16'h5660, 1'b1);
        chk("and_zero_nzp", {13'b0, nzp}, 16'h0002);
        run_instr(16'h1042, 1'b1);
        chk("add_reg_r0", regs[0], 16'hFFFF);
        run_instr(16'h4000, 1'b1);
        instr_valid = 1'b0;

        // LEA right after reset
        do_reset(1'b0);
        run_instr(16'hE605, 1'b0);
        instr_valid = 1'b0;
        chk("lea_nzp", {13'b0, nzp}, 16'h0002);
        chk("lea_r3", regs[3], 16'h3006);

        // Fetch stall, then TRAP
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ready", {15'b0, instr_ready}, 16'h0001);
            chk("stall_pc", pc, 16'h3001);
        end
        run_instr(16'hF025, 1'b0);
        instr_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_ready", {15'b0, instr_ready}, 16'h0000);
            chk("halt_pc", pc, 16'h3002);
            chk("halt_flag", {15'b0, halted}, 16'h0001);
        end
        instr_valid = 1'b0;

        // Reset during WB suppresses the write
        do_reset(1'b1);
        instr_valid = 1'b1;
        instr_data  = 16'h1261;
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midwb_accept", {15'b0, instr_ready}, 16'h0001);
        repeat (3) @(negedge clk);
        rst         = 1'b1;
        instr_valid = 1'b0;
        #1;
        chk("midwb_regwe", {15'b0, RegWE}, 16'h0000);
        @(negedge clk);
        chk("midwb_pc", pc, 16'h3000);
        chk("midwb_nzp", {13'b0, nzp}, 16'h0002);
        chk("midwb_halted", {15'b0, halted}, 16'h0000);
        chk("midwb_r1", regs[1], 16'h0000);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        chk("scoreboard_empty", 16'(exp_q.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/lc3_ctrl_fsm.md
# lc3_ctrl_fsm

Multi-cycle fetch/decode/execute/writeback controller for the 16-bit, 8-register CPU core. It sits directly upstream of the register file. It accepts instructions from the instruction source over a valid/ready handshake and drives the register file's read selects (`SR1`, `SR2`), write select (`DR`), write enable (`RegWE`) and write data (`write_value`). It executes ADD, AND, NOT, LEA, BR and TRAP (halt), and maintains the PC and the NZP condition codes.

## Interface
- `PC_RESET`, 16'h3000, PC value loaded on reset.
- Clock and reset: one clock; reset is synchronous and active-high. Ports are `clk` and `rst`.
- `clk` in 1: rising-edge clock, shared with the register file.
- `rst` in 1: synchronous, active-high reset.
- `instr_valid` in 1: the instruction source presents `instr_data`.
- `instr_data` in 16: instruction word fetched from address `pc`.
- `instr_ready` out 1: the controller accepts an instruction this cycle.
- `pc` out 16: fetch address, which is the address of the next instruction.
- `SR1_value` in 16: register file read port 1 data (combinational).
- `SR2_value` in 16: register file read port 2 data (combinational).
- `SR1`, `SR2`, `DR` out 3 each: register file selects.
- `RegWE` out 1: register file write enable.
- `write_value` out 16: register file write data.
- `nzp` out 3: condition codes {N,Z,P}.
- `halted` out 1: sticky; set by TRAP.

## Operation
- States are FETCH, DECODE, EXEC, WB and HALT. Reset enters FETCH.
- FETCH
  - `instr_ready=1`.
  - On `instr_valid & instr_ready`: IR <= `instr_data`; `pc` <= `pc`+1 (mod 2^16, FFFF wraps to 0000); go to DECODE.
  - Otherwise stay in FETCH.
- DECODE
  - `SR1`=IR[8:6], `SR2`=IR[2:0], `DR`=IR[11:9]. These are registered and held until the next DECODE.
  - Go to EXEC.
- EXEC: compute the result from `SR1_value`/`SR2_value` and register it. Go to WB.
  - ADD (0001): SR1_value + (IR[5] ? sext(IR[4:0]) : SR2_value), mod 2^16.
  - AND (0101): SR1_value & (IR[5] ? sext(IR[4:0]) : SR2_value).
  - NOT (1001): ~SR1_value.
  - LEA (1110): pc + sext(IR[8:0]), using the already-incremented `pc`.
  - BR (0000): taken = |(IR[11:9] & nzp).
  - TRAP (1111): go to HALT instead of WB.
  - Any other opcode: treated as a NOP, proceeds to WB with no effect.
- WB
  - ADD/AND/NOT/LEA: `RegWE=1` and `write_value`=result.
  - ADD/AND/NOT only: `nzp` <= N if result[15]=1, Z if result=0, P otherwise. LEA does not change `nzp`.
  - BR taken: `pc` <= `pc` + sext(IR[8:0]), mod 2^16.
  - Go to FETCH.
- HALT: `halted=1`, `instr_ready=0`, `RegWE=0`. Only `rst` exits this state.
- BR mask 000 is never taken; mask 111 is always taken.

## Timing
- Reset values while `rst`=1 and in the cycle after it:
  - `pc`=PC_RESET, `nzp`=3'b010, `halted`=0.
  - `SR1`=`SR2`=`DR`=0, `write_value`=0.
  - `RegWE`=0 and `instr_ready`=0; both are gated by `rst` in the same cycle.
- Cost per instruction: 4 cycles minimum, counted as the accept cycle plus DECODE, EXEC and WB. Extra FETCH cycles are spent while `instr_valid`=0.
- `instr_data` is sampled only on the accept edge; it is don't-care at all other times.
- `pc` changes on the accept edge, and again at the end of WB if a branch is taken.
- `RegWE` is high for exactly one cycle, in WB. The register file writes on the rising edge that ends WB, with `DR` and `write_value` stable throughout that cycle.
- `SR1`/`SR2` are stable from DECODE through WB, so the combinational read data is valid in EXEC.
- An instruction that reads a register written by the previous instruction sees the new value; the writeback completes before its DECODE.
- `rst` asserted in any state, including during WB, suppresses that cycle's write. The next state is FETCH with reset values.

## Test plan
- **ADD, then NOT.** Setup: registers all 0; words 0x1261 (ADD R1,R1,#1) and 0x947F (NOT R2,R1), `instr_valid` held high.
  - First WB: `DR`=1, `write_value`=0x0001, `RegWE`=1 for 1 cycle, `nzp`->001.
  - Second WB: `DR`=2, `write_value`=0xFFFE, `nzp`->100, `pc`=0x3002.
  - Accepts occur exactly 4 cycles apart.
- **Branch taken.** Same program, then 0x09FD (BRn #-3) at 0x3002: after WB, `pc`=0x3000 and `RegWE` stays 0 throughout.
- **Branch not taken.** 0x05FD (BRz #-3) with `nzp`=100: after WB, `pc`=0x3003.
- **LEA.** 0xE605 at 0x3000 just after reset: `DR`=3, `write_value`=0x3006, `nzp` remains 010.
- **Fetch stall, then halt.**
  - With `instr_valid`=0 for 5 cycles: `instr_ready`=1 and `pc` unchanged.
  - Then 0xF025: `halted`=1; `instr_ready`=0 for 20 further cycles with `instr_valid`=1; `pc` frozen.
- **Reset mid-writeback.** Assert `rst` during WB of 0x1261: `RegWE`=0 that cycle, R1 stays 0, and the next cycle shows `pc`=0x3000, `nzp`=010, `halted`=0.
